// File: rtl/mips_mem_pkg.sv
// Shared memory-path constants and the store-buffer entry layout used by the
// MEM stage, the store buffer and their test environment.
package mips_mem_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match finder: scans the live entries oldest to youngest starting at
// head, so the last hit seen is the most recent store to ld_addr_i.
module store_buffer_match #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] entry_addr_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PTR_W-1:0]  head_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              hit_o,
  output logic [PTR_W-1:0]  index_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hit_o   = 1'b0;
    index_o = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (entry_addr_i[idx] == ld_addr_i)) begin
        hit_o   = 1'b1;
        index_o = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM and data memory: stores enqueue in one
// cycle, drain in program order when no load owns the memory port.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH,
  parameter int unsigned ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_fwd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sb_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  valid;
  logic              push, pop;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;

  // Occupancy comes from count, so a full buffer with head == tail is unambiguous.
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign sb_empty = (count_q == '0);
  assign push     = st_valid && st_ready;
  assign pop      = mem_we;

  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .entry_addr_i (addr_q),
    .valid_i      (valid),
    .head_i       (head_q),
    .ld_addr_i    (ld_addr),
    .hit_o        (hit),
    .index_o      (hit_idx)
  );

  // Loads own the single address port; draining waits for a load-free cycle.
  assign mem_re    = ld_valid;
  assign mem_we    = !sb_empty && !ld_valid;
  assign mem_addr  = ld_valid ? ld_addr : addr_q[head_q];
  assign mem_wdata = data_q[head_q];
  assign ld_fwd    = ld_valid && hit;
  assign ld_data   = !ld_valid ? '0 : (hit ? data_q[hit_idx] : mem_rdata);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: the entry array is small and cleared on reset so stale addresses
      // never appear on mem_addr; larger RAM-style arrays would skip this.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the posted-write buffer.
module tb_store_buffer;
  import mips_mem_pkg::*;

  localparam int unsigned DEPTH = SB_DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              st_valid = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  logic              st_ready;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data;
  logic              ld_fwd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              sb_empty;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_fwd    (ld_fwd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sb_entry_t         model_q [$];
  logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] env_mem   [logic [ADDR_W-1:0]];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] env_read(input logic [ADDR_W-1:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  // One clock cycle: drive at negedge, check settled outputs, advance at posedge.
  task automatic step(input logic sv, input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                      input logic lv, input logic [ADDR_W-1:0] la);
    logic              exp_we, exp_ready, exp_fwd, push;
    logic [DATA_W-1:0] exp_ld;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_d;
    st_valid  = sv;  st_addr = sa;  st_data = sd;
    ld_valid  = lv;  ld_addr = la;
    mem_rdata = lv ? env_read(la) : DATA_W'($urandom);
    #1;
    exp_ready = (model_q.size() < DEPTH);
    exp_we    = (model_q.size() > 0) && !lv;
    exp_fwd   = 1'b0;
    exp_ld    = '0;
    if (lv) begin
      exp_ld = mem_rdata;
      for (int i = 0; i < model_q.size(); i++) begin
        if (model_q[i].addr == la) begin
          exp_fwd = 1'b1;
          exp_ld  = model_q[i].data;
        end
      end
    end
    check("st_ready", 64'(st_ready), 64'(exp_ready));
    check("sb_empty", 64'(sb_empty), 64'(model_q.size() == 0));
    check("mem_we",   64'(mem_we),   64'(exp_we));
    check("mem_re",   64'(mem_re),   64'(lv));
    check("ld_fwd",   64'(ld_fwd),   64'(exp_fwd));
    check("ld_data",  64'(ld_data),  64'(exp_ld));
    if (lv) check("mem_addr_ld", 64'(mem_addr), 64'(la));
    if (exp_we) begin
      check("drain_addr",  64'(mem_addr),  64'(model_q[0].addr));
      check("drain_wdata", 64'(mem_wdata), 64'(model_q[0].data));
    end
    cap_we = mem_we;  cap_a = mem_addr;  cap_d = mem_wdata;
    push = sv && exp_ready;
    @(posedge clk);
    if (cap_we) env_mem[cap_a] = cap_d;
    if (exp_we) begin
      model_mem[model_q[0].addr] = model_q[0].data;
      void'(model_q.pop_front());
    end
    if (push) model_q.push_back('{addr: sa, data: sd});
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;  st_valid = 1'b0;  ld_valid = 1'b0;
    #1;
    check("rst_mem_we",   64'(mem_we),   64'd0);
    check("rst_sb_empty", 64'(sb_empty), 64'd1);
    check("rst_st_ready", 64'(st_ready), 64'd1);
    check("rst_ld_fwd",   64'(ld_fwd),   64'd0);
    check("rst_ld_data",  64'(ld_data),  64'd0);
    model_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // 1: single store drains the next cycle.
    step(1'b1, 32'd5, 32'hAA, 1'b0, '0);
    idle();
    idle();

    // 2: fill under a load stream, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 32'(i * 16), 1'b1, 32'd9);
    step(1'b0, '0, '0, 1'b1, 32'd9);
    for (int i = 0; i < 5; i++) idle();

    // 3: youngest-match forwarding, then a miss.
    step(1'b1, 32'd7, 32'h11, 1'b1, 32'd9);
    step(1'b1, 32'd7, 32'h22, 1'b1, 32'd9);
    step(1'b0, '0, '0, 1'b1, 32'd7);
    step(1'b0, '0, '0, 1'b1, 32'd8);
    for (int i = 0; i < 3; i++) idle();

    // 4: store to a full buffer during a drain is dropped; the next is accepted.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(20 + i), 32'(32'h100 + i), 1'b1, 32'd21);
    step(1'b1, 32'd30, 32'hDEAD, 1'b0, '0);
    step(1'b1, 32'd31, 32'hBEEF, 1'b0, '0);
    for (int i = 0; i < 5; i++) idle();

    // 5: rounds that walk the pointers past the wrap point.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++)
        step(1'b1, 32'(40 + i), 32'(r * 256 + i), 1'b1, 32'(40 + (r % 3)));
      step(1'b0, '0, '0, 1'b1, 32'(40 + r % 3));
      for (int i = 0; i < 2; i++) idle();
    end
    for (int i = 0; i < 3; i++) idle();

    // 6: reset with three stores still pending.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(60 + i), 32'(32'h600 + i), 1'b1, 32'd99);
    idle();
    do_reset();
    step(1'b0, '0, '0, 1'b1, 32'd62);
    step(1'b0, '0, '0, 1'b1, 32'd63);

    // Random traffic over a small address range to exercise hits and wrap.
    for (int n = 0; n < 600; n++) begin
      step(1'b1 & ($urandom_range(0, 2) != 0), 32'($urandom_range(0, 7)), DATA_W'($urandom),
           ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 7)));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle();

    foreach (model_mem[a]) begin
      check("mem_contents", 64'(env_read(a)), 64'(model_mem[a]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
